ycbcr_block_scheduler: RTL and testbench

- Sequences one 8x8 RGB block at a time through the shared colour-conversion engine (rgb2ycbcr_container) and presents the results downstream.
- Accepts a block through a valid/ready handshake and latches it. Pulses the engine start, waits for its done pulse, captures Y/Cb/Cr, then holds them until downstream accepts.
- Sits between the block fetcher and the DCT stage. Adds a done-timeout watchdog and a block counter for debug.

---
 rtl/ycbcr_block_scheduler_if.sv | 30 +++
 rtl/ycbcr_block_scheduler.sv | 107 ++++++++++
 tb/tb_ycbcr_block_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ycbcr_block_scheduler_if.sv
// ycbcr_block_scheduler_if: input block handshake, engine link and result handshake for the scheduler
interface ycbcr_block_scheduler_if #(
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int PIXEL_COUNT = 64
);
  localparam int IW = INPUT_WIDTH * PIXEL_COUNT;
  localparam int FW = FIXED_POINT_LENGTH * PIXEL_COUNT;
  logic in_valid;
  logic in_ready;
  logic [IW-1:0] r_in, g_in, b_in;
  logic conv_start;
  logic [IW-1:0] conv_r, conv_g, conv_b;
  logic conv_done;
  logic [FW-1:0] conv_y, conv_cb, conv_cr;
  logic out_valid;
  logic out_ready;
  logic [FW-1:0] y_out, cb_out, cr_out;
  logic err;
  logic err_clr;
  logic [15:0] block_count;
  modport master (
    output in_valid, r_in, g_in, b_in, conv_done, conv_y, conv_cb, conv_cr, out_ready, err_clr,
    input in_ready, conv_start, conv_r, conv_g, conv_b, out_valid, y_out, cb_out, cr_out, err, block_count
  );
  modport slave (
    input in_valid, r_in, g_in, b_in, conv_done, conv_y, conv_cb, conv_cr, out_ready, err_clr,
    output in_ready, conv_start, conv_r, conv_g, conv_b, out_valid, y_out, cb_out, cr_out, err, block_count
  );
endinterface

// File: rtl/ycbcr_block_scheduler.sv
// ycbcr_block_scheduler: runs one 8x8 RGB block at a time through the colour engine, with done watchdog and block counter
module ycbcr_block_scheduler #(
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int PIXEL_COUNT = 64,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  ycbcr_block_scheduler_if.slave bus
);
  localparam int IW = INPUT_WIDTH * PIXEL_COUNT;
  localparam int FW = FIXED_POINT_LENGTH * PIXEL_COUNT;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [FW-1:0] y_q, cb_q, cr_q, y_d, cb_d, cr_d;
  logic start_q, valid_q, err_q, err_d;
  logic [15:0] count_q, count_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    y_d = y_q;
    cb_d = cb_q;
    cr_d = cr_q;
    err_d = bus.err_clr ? 1'b0 : err_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        r_d = bus.r_in;
        g_d = bus.g_in;
        b_d = bus.b_in;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // done on the final watchdog cycle still counts as success
        if (bus.conv_done) begin
          y_d = bus.conv_y;
          cb_d = bus.conv_cb;
          cr_d = bus.conv_cr;
          state_d = OUTPUT;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      OUTPUT: if (bus.out_ready) begin
        count_d = count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      y_q <= '0;
      cb_q <= '0;
      cr_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      y_q <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
      start_q <= state_d == LAUNCH;
      valid_q <= state_d == OUTPUT;
      err_q <= err_d;
      count_q <= count_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.conv_start = start_q;
  assign bus.conv_r = r_q;
  assign bus.conv_g = g_q;
  assign bus.conv_b = b_q;
  assign bus.out_valid = valid_q;
  assign bus.y_out = y_q;
  assign bus.cb_out = cb_q;
  assign bus.cr_out = cr_q;
  assign bus.err = err_q;
  assign bus.block_count = count_q;
endmodule

// File: tb/tb_ycbcr_block_scheduler.sv
// tb_ycbcr_block_scheduler: timeline model of the scheduler against a stub colour engine with programmable done delay
module tb_ycbcr_block_scheduler;
  localparam int PC = 64;
  localparam int IW = 8 * PC;
  localparam int FW = 32 * PC;
  localparam int T = 32;
  logic clk, rst;
  ycbcr_block_scheduler_if bus ();
  ycbcr_block_scheduler #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, nstart = 0, cd = 0, delay = 10;
  logic spur;
  logic [31:0] salt;
  logic chk;
  logic e_ready, e_start, e_valid, e_err;
  logic [15:0] e_count;
  logic [FW-1:0] e_y, e_cb, e_cr;
  logic [3*IW-1:0] e_cin;
  logic [IW-1:0] ra, ga, ba, lr, lg, lb, zr;
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [FW-1:0] eng(input logic [IW-1:0] r, g, b, input int ch);
    logic [FW-1:0] v;
    v = '0;
    for (int p = 0; p < PC; p++) begin
      int rr, gg, bb, val;
      rr = int'(r[p*8+:8]);
      gg = int'(g[p*8+:8]);
      bb = int'(b[p*8+:8]);
      val = ch == 0 ? 16 + rr + 2 * gg + bb : ch == 1 ? 128 + 2 * bb - rr : 128 + 2 * rr - gg;
      v[p*32+:32] = 32'(val);
    end
    return v;
  endfunction
  // stub engine: done arrives delay cycles after the start pulse (delay 0 = never)
  always @(posedge clk or posedge rst)
    if (rst) cd <= 0;
    else if (bus.conv_start) cd <= delay;
    else if (cd > 0) cd <= cd - 1;
  always @(posedge clk) if (!rst && bus.conv_start) nstart <= nstart + 1;
  assign bus.conv_done = (cd == 1) | spur;
  assign bus.conv_y = eng(bus.conv_r, bus.conv_g, bus.conv_b, 0) ^ {PC{salt}};
  assign bus.conv_cb = eng(bus.conv_r, bus.conv_g, bus.conv_b, 1) ^ {PC{salt}};
  assign bus.conv_cr = eng(bus.conv_r, bus.conv_g, bus.conv_b, 2) ^ {PC{salt}};
  task automatic cmp(input string n, input logic [2047:0] a, input logic [2047:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      for (int i = 0; i < 64; i++)
        if (a[i*32+:32] !== e[i*32+:32]) begin
          $display("FAIL %s t=%0t word %0d: got %h expected %h", n, $time, i, a[i*32+:32], e[i*32+:32]);
          break;
        end
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("in_ready", 2048'(bus.in_ready), 2048'(e_ready));
    cmp("conv_start", 2048'(bus.conv_start), 2048'(e_start));
    cmp("out_valid", 2048'(bus.out_valid), 2048'(e_valid));
    cmp("err", 2048'(bus.err), 2048'(e_err));
    cmp("block_count", 2048'(bus.block_count), 2048'(e_count));
    cmp("y_out", 2048'(bus.y_out), 2048'(e_y));
    cmp("cb_out", 2048'(bus.cb_out), 2048'(e_cb));
    cmp("cr_out", 2048'(bus.cr_out), 2048'(e_cr));
    cmp("conv_rgb", 2048'({bus.conv_b, bus.conv_g, bus.conv_r}), 2048'(e_cin));
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_expect;
    e_ready = 1; e_start = 0; e_valid = 0; e_err = 0; e_count = 0;
    e_y = '0; e_cb = '0; e_cr = '0; e_cin = '0;
  endtask
  // d in 1..T: done arrives in cycle d+1 after acceptance; d = 0: engine never answers
  task automatic send(input logic [IW-1:0] r, g, b, input int d, input int hold, input bit clr);
    bus.in_valid = 1; bus.r_in = r; bus.g_in = g; bus.b_in = b; delay = d;
    step;
    bus.in_valid = 0; e_ready = 0; e_start = 1; e_cin = {b, g, r};
    step;
    e_start = 0;
    if (d == 0) begin
      repeat (T - 1) step;
      bus.err_clr = clr;
      step;
      bus.err_clr = 0; e_err = 1; e_ready = 1;
    end else begin
      repeat (d) step;
      e_valid = 1; e_y = eng(r, g, b, 0); e_cb = eng(r, g, b, 1); e_cr = eng(r, g, b, 2);
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1; bus.r_in = ~r;
        spur = i == hold / 2;
        salt = spur ? 32'h5a5a_5a5a : 32'h0;
        step;
      end
      spur = 0; salt = 0; bus.in_valid = 0; bus.out_ready = 1;
      step;
      bus.out_ready = 0; e_valid = 0; e_ready = 1; e_count = e_count + 16'd1;
    end
  endtask
  task automatic clear_err;
    bus.err_clr = 1;
    step;
    bus.err_clr = 0; e_err = 0;
  endtask
  initial begin
    rst = 1; chk = 1; spur = 0; salt = 0;
    bus.in_valid = 0; bus.out_ready = 0; bus.err_clr = 0;
    bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;
    reset_expect();
    zr = '0;
    for (int p = 0; p < PC; p++) begin
      ra[p*8+:8] = 8'(p); ga[p*8+:8] = 8'(2 * p + 1); ba[p*8+:8] = 8'(255 - p);
      lr[p*8+:8] = 8'd10; lg[p*8+:8] = 8'd20; lb[p*8+:8] = 8'd30;
    end
    step; step;
    rst = 0;
    send(zr, zr, zr, 10, 0, 0);
    cmp("black_y", 2048'(bus.y_out[31:0]), 2048'(32'd16));
    cmp("black_cb", 2048'(bus.cb_out[31:0]), 2048'(32'd128));
    cmp("black_cr", 2048'(bus.cr_out[31:0]), 2048'(32'd128));
    cmp("black_count", 2048'(bus.block_count), 2048'(16'd1));
    cmp("black_starts", 2048'(nstart), 2048'(1));
    send(ra, ga, ba, 10, 20, 0);
    cmp("bp_y5", 2048'(bus.y_out[5*32+:32]), 2048'(32'd293));
    cmp("bp_cb5", 2048'(bus.cb_out[5*32+:32]), 2048'(32'd623));
    cmp("bp_cr5", 2048'(bus.cr_out[5*32+:32]), 2048'(32'd127));
    cmp("bp_count", 2048'(bus.block_count), 2048'(16'd2));
    send(lr, lg, lb, 3, 2, 0);
    cmp("lit_y", 2048'(bus.y_out[63*32+:32]), 2048'(32'd96));
    cmp("lit_cb", 2048'(bus.cb_out[63*32+:32]), 2048'(32'd178));
    cmp("lit_cr", 2048'(bus.cr_out[63*32+:32]), 2048'(32'd128));
    spur = 1; salt = 32'h1234_5678;
    step;
    spur = 0; salt = 0;
    step;
    send(ra, ga, ba, 0, 0, 0);
    cmp("timeout_err", 2048'(bus.err), 2048'(1'b1));
    clear_err();
    cmp("timeout_clr", 2048'(bus.err), 2048'(1'b0));
    send(lr, lg, lb, 0, 0, 1);
    cmp("set_wins", 2048'(bus.err), 2048'(1'b1));
    clear_err();
    send(ra, ga, ba, T, 1, 0);
    cmp("race_count", 2048'(bus.block_count), 2048'(16'd4));
    bus.in_valid = 1; bus.r_in = lr; bus.g_in = lg; bus.b_in = lb; delay = 10;
    step;
    bus.in_valid = 0; e_ready = 0; e_start = 1; e_cin = {lb, lg, lr};
    step;
    e_start = 0;
    step; step;
    #2 rst = 1;
    reset_expect();
    #1 cmp("async_ready", 2048'(bus.in_ready), 2048'(1'b1));
    cmp("async_count", 2048'(bus.block_count), 2048'(16'd0));
    step;
    rst = 0;
    send(ra, lg, ba, 5, 0, 0);
    cmp("after_rst_count", 2048'(bus.block_count), 2048'(16'd1));
    force dut.count_q = 16'hffff;
    e_count = 16'hffff;
    step;
    release dut.count_q;
    step;
    send(lr, ga, lb, 10, 0, 0);
    cmp("wrap_count", 2048'(bus.block_count), 2048'(16'd0));
    step;
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
